ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist_pkg.sv | 44 ++++
 rtl/ram_bist_pat.sv | 58 +++++
 rtl/ram_bist.sv | 186 ++++++++++++++++++
 tb/tb_ram_bist.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM BIST: FSM state encoding, 3-bit phase codes
// reported on err_phase, and small helpers mapping a state to its phase
// code and to the phase that follows it.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0W1,
    R1W0,
    BL,
    FIN,
    DONE
  } state_t;

  localparam logic [2:0] PH_NONE = 3'd0;
  localparam logic [2:0] PH_W0   = 3'd1;
  localparam logic [2:0] PH_R0W1 = 3'd2;
  localparam logic [2:0] PH_R1W0 = 3'd3;
  localparam logic [2:0] PH_BL   = 3'd4;
  localparam logic [2:0] PH_FIN  = 3'd5;

  function automatic logic [2:0] phase_of(input state_t s);
    case (s)
      W0:      phase_of = PH_W0;
      R0W1:    phase_of = PH_R0W1;
      R1W0:    phase_of = PH_R1W0;
      BL:      phase_of = PH_BL;
      FIN:     phase_of = PH_FIN;
      default: phase_of = PH_NONE;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      W0:      next_phase = R0W1;
      R0W1:    next_phase = R1W0;
      R1W0:    next_phase = BL;
      BL:      next_phase = FIN;
      default: next_phase = DONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_pat.sv
// Pattern generator: combinationally derives the expected read word and the
// write word for a given phase code and address.
//   phase    : 3-bit phase code (PH_*), PH_NONE yields zeros
//   addr     : RAM address
//   exp_word : word the read in this phase must return
//   wr_word  : word this phase writes
module ram_bist_pat
  import ram_bist_pkg::*;
#(
  parameter int          ABITS = 5,
  parameter int          DBITS = 32,
  parameter logic [31:0] SEED  = 32'hDEAD_BEEF
) (
  input  logic [2:0]       phase,
  input  logic [ABITS-1:0] addr,
  output logic [DBITS-1:0] exp_word,
  output logic [DBITS-1:0] wr_word
);

  localparam int L = DBITS / 8;

  // SEED repeated every 32 bits, cut to DBITS
  function automatic logic [DBITS-1:0] rep_seed();
    logic [DBITS-1:0] r;
    for (int i = 0; i < DBITS; i++) r[i] = SEED[i % 32];
    return r;
  endfunction

  localparam logic [DBITS-1:0] SEED_W = rep_seed();

  logic [DBITS-1:0] pat;
  logic [DBITS-1:0] bl_word;

  assign pat = SEED_W ^ DBITS'(addr);

  // after the byte-lane write, even lanes hold ~P(a), odd lanes still P(a)
  for (genvar l = 0; l < L; l++) begin : g_lane
    if (l % 2 == 0) begin : g_even
      assign bl_word[8*l +: 8] = ~pat[8*l +: 8];
    end else begin : g_odd
      assign bl_word[8*l +: 8] = pat[8*l +: 8];
    end
  end

  always_comb begin
    exp_word = '0;
    wr_word  = '0;
    case (phase)
      PH_W0:   wr_word = pat;
      PH_R0W1: begin exp_word = pat;     wr_word = ~pat; end
      PH_R1W0: begin exp_word = ~pat;    wr_word = pat;  end
      PH_BL:   begin exp_word = bl_word; wr_word = ~pat; end
      PH_FIN:  exp_word = bl_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// March-style RAM BIST controller.
// Runs W0, R0W1 (asc), R1W0 (desc), BL (byte-lane, asc) and FIN (asc) over
// all 2^ABITS addresses and stops at the first read mismatch.
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle run request (accepted in IDLE/DONE)
//   busy, done, pass  : run status; pass valid while done
//   err_phase/addr    : phase code and address of first mismatch
//   err_exp/err_act   : expected and read-back word of first mismatch
//   ram_we            : per-byte write enables (combinational)
//   ram_addr/wdata    : registered RAM address and write data
//   ram_rdata         : read data, RD_LAT cycles after the address cycle
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int          ABITS  = 5,
  parameter int          DBITS  = 32,
  parameter int          RD_LAT = 1,
  parameter logic [31:0] SEED   = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_phase,
  output logic [ABITS-1:0]   err_addr,
  output logic [DBITS-1:0]   err_exp,
  output logic [DBITS-1:0]   err_act,
  output logic [DBITS/8-1:0] ram_we,
  output logic [ABITS-1:0]   ram_addr,
  output logic [DBITS-1:0]   ram_wdata,
  input  logic [DBITS-1:0]   ram_rdata
);

  localparam int L = DBITS / 8;

  function automatic logic [L-1:0] even_lanes();
    logic [L-1:0] m;
    for (int l = 0; l < L; l++) m[l] = (l % 2 == 0);
    return m;
  endfunction

  localparam logic [L-1:0] EVEN_WE = even_lanes();
  // slot-relative cycle of the compare (read + RD_LAT) and of the last cycle
  localparam logic [2:0]   C_CMP   = 3'(RD_LAT);
  localparam logic [2:0]   C_LAST  = 3'(RD_LAT + 1);

  state_t           state, state_n;
  logic [2:0]       cyc, cyc_n;
  logic [ABITS-1:0] addr_n;
  logic [DBITS-1:0] exp_q, exp_n, wdata_n;
  logic             pass_n;
  logic [2:0]       err_phase_n;
  logic [ABITS-1:0] err_addr_n;
  logic [DBITS-1:0] err_exp_n, err_act_n;
  logic             cmp_cyc, wr_cyc, last_cyc, last_addr, desc, mism;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // slot decode: where inside the per-address slot we are
  always_comb begin
    cmp_cyc  = 1'b0;
    wr_cyc   = 1'b0;
    last_cyc = 1'b0;
    case (state)
      W0: begin
        wr_cyc   = 1'b1;
        last_cyc = 1'b1;
      end
      R0W1, R1W0: begin
        cmp_cyc  = (cyc == C_CMP);
        wr_cyc   = (cyc == C_LAST);
        last_cyc = (cyc == C_LAST);
      end
      BL: begin
        wr_cyc   = (cyc == 3'd0);
        cmp_cyc  = (cyc == C_LAST);
        last_cyc = (cyc == C_LAST);
      end
      FIN: begin
        cmp_cyc  = (cyc == C_CMP);
        last_cyc = (cyc == C_CMP);
      end
      default: ;
    endcase
  end

  assign desc      = (state == R1W0);
  assign last_addr = desc ? (ram_addr == '0) : (ram_addr == '1);
  assign mism      = cmp_cyc && (ram_rdata != exp_q);

  // a mismatching compare never coincides with a write, gated anyway
  always_comb begin
    ram_we = '0;
    if (wr_cyc && !mism) ram_we = (state == BL) ? EVEN_WE : '1;
  end

  always_comb begin
    state_n     = state;
    addr_n      = ram_addr;
    cyc_n       = cyc;
    pass_n      = pass;
    err_phase_n = err_phase;
    err_addr_n  = err_addr;
    err_exp_n   = err_exp;
    err_act_n   = err_act;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = W0;
          addr_n      = '0;
          cyc_n       = '0;
          pass_n      = 1'b0;
          err_phase_n = '0;
          err_addr_n  = '0;
          err_exp_n   = '0;
          err_act_n   = '0;
        end
      end
      default: begin
        if (mism) begin
          state_n     = DONE;
          pass_n      = 1'b0;
          err_phase_n = phase_of(state);
          err_addr_n  = ram_addr;
          err_exp_n   = exp_q;
          err_act_n   = ram_rdata;
        end else if (last_cyc) begin
          cyc_n = '0;
          if (last_addr) begin
            // address wraps only here, at the phase boundary
            state_n = next_phase(state);
            addr_n  = (next_phase(state) == R1W0) ? '1 : '0;
            if (state == FIN) pass_n = 1'b1;
          end else begin
            addr_n = desc ? ram_addr - ABITS'(1) : ram_addr + ABITS'(1);
          end
        end else begin
          cyc_n = cyc + 3'd1;
        end
      end
    endcase
  end

  // patterns for the next cycle's phase/address, so wdata and the compare
  // word come straight from flops
  ram_bist_pat #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .SEED  (SEED)
  ) u_pat (
    .phase    (phase_of(state_n)),
    .addr     (addr_n),
    .exp_word (exp_n),
    .wr_word  (wdata_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      exp_q     <= '0;
      pass      <= 1'b0;
      err_phase <= '0;
      err_addr  <= '0;
      err_exp   <= '0;
      err_act   <= '0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      ram_addr  <= addr_n;
      ram_wdata <= wdata_n;
      exp_q     <= exp_n;
      pass      <= pass_n;
      err_phase <= err_phase_n;
      err_addr  <= err_addr_n;
      err_exp   <= err_exp_n;
      err_act   <= err_act_n;
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (RD_LAT 1 and 3), each with a RAM model
// that can inject a read-path stuck bit or ignore byte enables. Expected
// outcomes come from a loop-level model of the march algorithm.
module tb_ram_bist;

  localparam int BUDGET = 2000;
  localparam logic [31:0] EVEN = 32'h00FF_00FF;

  logic        clk;
  logic        start_s [2];
  logic        rst_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic [2:0]  eph_s   [2];
  logic [4:0]  eaddr_s [2];
  logic [31:0] eexp_s  [2];
  logic [31:0] eact_s  [2];
  logic [3:0]  we_s    [2];
  logic [4:0]  addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];

  logic [31:0] mem  [2][32];
  logic [31:0] pipe [2][4];
  int          f_kind [2];
  int          f_addr [2];
  int          f_bit  [2];
  bit          f_val  [2];

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_bist #(.ABITS(5), .DBITS(32), .RD_LAT(1), .SEED(32'hDEAD_BEEF)) u0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_phase(eph_s[0]),
    .err_addr(eaddr_s[0]), .err_exp(eexp_s[0]), .err_act(eact_s[0]),
    .ram_we(we_s[0]), .ram_addr(addr_s[0]), .ram_wdata(wdata_s[0]),
    .ram_rdata(rdata_s[0]));

  ram_bist #(.ABITS(5), .DBITS(32), .RD_LAT(3), .SEED(32'hDEAD_BEEF)) u1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_phase(eph_s[1]),
    .err_addr(eaddr_s[1]), .err_exp(eexp_s[1]), .err_act(eact_s[1]),
    .ram_we(we_s[1]), .ram_addr(addr_s[1]), .ram_wdata(wdata_s[1]),
    .ram_rdata(rdata_s[1]));

  function automatic logic [31:0] pw(input int a);
    return 32'hDEAD_BEEF ^ 32'(a);
  endfunction

  // kind 1: bit fb of reads from address fa forced to fv
  function automatic logic [31:0] rdf(input logic [31:0] v, input int a,
                                      input int kind, input int fa,
                                      input int fb, input bit fv);
    logic [31:0] r;
    r = v;
    if (kind == 1 && a == fa) r[fb] = fv;
    return r;
  endfunction

  function automatic int rl_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // RAM models: read pipeline RD_LAT deep, kind 2 writes all lanes
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= rdf(mem[d][addr_s[d]], int'(addr_s[d]), f_kind[d],
                        f_addr[d], f_bit[d], f_val[d]);
      for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
      for (int l = 0; l < 4; l++)
        if (we_s[d][l] || (f_kind[d] == 2 && we_s[d] != 4'd0))
          mem[d][addr_s[d]][8*l +: 8] <= wdata_s[d][8*l +: 8];
    end
  end
  assign rdata_s[0] = pipe[0][0];
  assign rdata_s[1] = pipe[1][2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk the march over a private memory image; t is the edge count from
  // the start-sampling edge to done (compare cycle + 1 on a mismatch).
  task automatic model(input int rl, input int kind, input int fa,
                       input int fb, input bit fv, output int t,
                       output bit mp, output logic [2:0] ph,
                       output logic [4:0] ea, output logic [31:0] ee,
                       output logic [31:0] eo);
    logic [31:0] m [32];
    logic [31:0] r, x;
    int c;
    bit found;
    c = 0; found = 0; t = 0; ph = 0; ea = 0; ee = 0; eo = 0;
    for (int a = 0; a < 32; a++) begin m[a] = pw(a); c++; end
    for (int a = 0; a < 32; a++) if (!found) begin
      r = rdf(m[a], a, kind, fa, fb, fv);
      if (r !== pw(a)) begin
        found = 1; ph = 3'd2; ea = 5'(a); ee = pw(a); eo = r; t = c + rl + 1;
      end else begin m[a] = ~pw(a); c += rl + 2; end
    end
    for (int a = 31; a >= 0; a--) if (!found) begin
      r = rdf(m[a], a, kind, fa, fb, fv);
      if (r !== ~pw(a)) begin
        found = 1; ph = 3'd3; ea = 5'(a); ee = ~pw(a); eo = r; t = c + rl + 1;
      end else begin m[a] = pw(a); c += rl + 2; end
    end
    for (int a = 0; a < 32; a++) if (!found) begin
      m[a] = (kind == 2) ? ~pw(a) : ((m[a] & ~EVEN) | (~pw(a) & EVEN));
      x = pw(a) ^ EVEN;
      r = rdf(m[a], a, kind, fa, fb, fv);
      if (r !== x) begin
        found = 1; ph = 3'd4; ea = 5'(a); ee = x; eo = r; t = c + rl + 2;
      end else c += rl + 2;
    end
    for (int a = 0; a < 32; a++) if (!found) begin
      x = pw(a) ^ EVEN;
      r = rdf(m[a], a, kind, fa, fb, fv);
      if (r !== x) begin
        found = 1; ph = 3'd5; ea = 5'(a); ee = x; eo = r; t = c + rl + 1;
      end else c += rl + 1;
    end
    if (!found) t = c;
    mp = !found;
  endtask

  task automatic chk_idle(input int d, input string pfx);
    chk({pfx, "_busy"},  64'(busy_s[d]),  64'd0);
    chk({pfx, "_done"},  64'(done_s[d]),  64'd0);
    chk({pfx, "_pass"},  64'(pass_s[d]),  64'd0);
    chk({pfx, "_we"},    64'(we_s[d]),    64'd0);
    chk({pfx, "_addr"},  64'(addr_s[d]),  64'd0);
    chk({pfx, "_wdata"}, 64'(wdata_s[d]), 64'd0);
    chk({pfx, "_eph"},   64'(eph_s[d]),   64'd0);
    chk({pfx, "_eaddr"}, 64'(eaddr_s[d]), 64'd0);
    chk({pfx, "_eexp"},  64'(eexp_s[d]),  64'd0);
    chk({pfx, "_eact"},  64'(eact_s[d]),  64'd0);
  endtask

  task automatic run(input int d, input int kind, input int fa, input int fb,
                     input bit fv, input string pfx);
    int t, k, rk;
    bit mp;
    logic [2:0] ph;
    logic [4:0] ea;
    logic [31:0] ee, eo;
    f_kind[d] = kind; f_addr[d] = fa; f_bit[d] = fb; f_val[d] = fv;
    model(rl_of(d), kind, fa, fb, fv, t, mp, ph, ea, ee, eo);
    @(negedge clk); start_s[d] = 1'b1;
    @(negedge clk); start_s[d] = 1'b0;
    // first W0 cycle: status cleared, writing P(0) at address 0
    chk({pfx, "_busy1"},  64'(busy_s[d]),  64'd1);
    chk({pfx, "_done0"},  64'(done_s[d]),  64'd0);
    chk({pfx, "_pass0"},  64'(pass_s[d]),  64'd0);
    chk({pfx, "_eclr"},   {eexp_s[d], eact_s[d]}, 64'd0);
    chk({pfx, "_eaclr"},  64'({eph_s[d], eaddr_s[d]}), 64'd0);
    chk({pfx, "_w0addr"}, 64'(addr_s[d]),  64'd0);
    chk({pfx, "_w0data"}, 64'(wdata_s[d]), 64'(pw(0)));
    chk({pfx, "_w0we"},   64'(we_s[d]),    64'hF);
    rk = $urandom_range(1, 20);
    for (k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (done_s[d]) break;
      start_s[d] = (k == rk);  // stray start while busy
    end
    start_s[d] = 1'b0;
    chk({pfx, "_edges"}, 64'(k), 64'(t));
    chk({pfx, "_pass"},  64'(pass_s[d]),  64'(mp));
    chk({pfx, "_eph"},   64'(eph_s[d]),   64'(ph));
    chk({pfx, "_eaddr"}, 64'(eaddr_s[d]), 64'(ea));
    chk({pfx, "_eexp"},  64'(eexp_s[d]),  64'(ee));
    chk({pfx, "_eact"},  64'(eact_s[d]),  64'(eo));
    chk({pfx, "_dbusy"}, 64'(busy_s[d]),  64'd0);
    chk({pfx, "_dwe"},   64'(we_s[d]),    64'd0);
  endtask

  initial begin
    int d, kind, fa, fb;
    bit fv;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; rst_s[i] = 1'b1;
      f_kind[i] = 0; f_addr[i] = 0; f_bit[i] = 0; f_val[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;

    run(0, 0, 0, 0, 1'b0, "clean1");
    run(0, 1, 5, 3, 1'b0, "stuck5");
    chk("stuck5_k_eexp", 64'(eexp_s[0]), 64'h0000_0000_DEAD_BEEA);
    chk("stuck5_k_eact", 64'(eact_s[0]), 64'h0000_0000_DEAD_BEE2);
    run(0, 2, 0, 0, 1'b0, "nobe");
    chk("nobe_k_eexp", 64'(eexp_s[0]), 64'h0000_0000_DE52_BE10);
    chk("nobe_k_eact", 64'(eact_s[0]), 64'h0000_0000_2152_4110);
    run(1, 0, 0, 0, 1'b0, "clean3");

    for (int i = 0; i < 6; i++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      fa   = int'($urandom_range(0, 31));
      fb   = int'($urandom_range(0, 31));
      fv   = 1'($urandom_range(0, 1));
      run(d, kind, fa, fb, fv, $sformatf("rnd%0d", i));
    end

    // abort mid-run, with a start held alongside reset
    f_kind[0] = 0;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (49) @(negedge clk);
    chk("abort_prebusy", 64'(busy_s[0]), 64'd1);
    rst_s[0] = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    chk_idle(0, "abort");
    rst_s[0] = 1'b0; start_s[0] = 1'b0;
    @(negedge clk);
    chk("rststart_busy", 64'(busy_s[0]), 64'd0);
    chk("rststart_we",   64'(we_s[0]),   64'd0);
    run(0, 0, 0, 0, 1'b0, "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
